// File: rtl/kernel_addr_sequencer.sv
// -----------------------------------------------------------------------------
// kernel_addr_sequencer
//
// Raster-scan controller for the 3x3 convolution kernel address path. A start
// command walks a configured frame one output pixel at a time. For every pixel
// it presents the top-, centre- and bottom-row addresses of the kernel window.
// The top and bottom rows are clamped (replicated) at the frame edges.
//
// Ports
//   clk         rising-edge clock
//   rst_n       asynchronous, active-low reset
//   start       1-cycle command, only looked at in IDLE
//   abort       synchronous scan termination; no done pulse follows
//   cfg_base    frame base address, latched at an accepted start
//   cfg_width   pixels per row, latched at start
//   cfg_height  rows per frame, latched at start
//   out_ready   consumer accepts the current window
//   out_valid   window outputs valid
//   top_addr    address of the row above the centre pixel (clamped)
//   mid_addr    centre pixel address
//   bot_addr    address of the row below the centre pixel (clamped)
//   col, row    coordinates of the current window
//   top_clamp   row == 0
//   bot_clamp   row == height-1
//   busy        high while scanning (RUN)
//   done        1-cycle pulse after the last window is accepted
//
// Handshake: a window transfers on every rising edge where out_valid and
// out_ready are both high. While out_valid is high and out_ready is low, every
// window output holds its value. out_valid never drops in RUN except through
// abort or reset, and it does not depend on out_ready.
//
// All outputs come straight from flops. The next window is computed from the
// next-state coordinates, then registered. No multiplier is used: the row base
// address is accumulated by adding the width once per completed row.
// -----------------------------------------------------------------------------
module kernel_addr_sequencer #(
  parameter int AW = 16,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          abort,
  input  logic [AW-1:0] cfg_base,
  input  logic [DW-1:0] cfg_width,
  input  logic [DW-1:0] cfg_height,
  input  logic          out_ready,
  output logic          out_valid,
  output logic [AW-1:0] top_addr,
  output logic [AW-1:0] mid_addr,
  output logic [AW-1:0] bot_addr,
  output logic [DW-1:0] col,
  output logic [DW-1:0] row,
  output logic          top_clamp,
  output logic          bot_clamp,
  output logic          busy,
  output logic          done
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  // State and latched configuration
  logic [1:0]    state;
  logic [DW-1:0] width_q;
  logic [DW-1:0] height_q;
  logic [AW-1:0] row_base;

  // Next-state values
  logic [1:0]    state_d;
  logic [DW-1:0] width_d;
  logic [DW-1:0] height_d;
  logic [AW-1:0] row_base_d;
  logic [DW-1:0] col_d;
  logic [DW-1:0] row_d;
  logic          out_valid_d;
  logic          busy_d;
  logic          done_d;
  logic          load_win;

  // Next window, derived from the next-state coordinates
  logic [AW-1:0] mid_d;
  logic [AW-1:0] top_d;
  logic [AW-1:0] bot_d;
  logic          top_clamp_d;
  logic          bot_clamp_d;
  logic [AW-1:0] width_ext_d;

  logic handshake;
  logic last_col;
  logic last_row;

  assign handshake = out_valid && out_ready;
  assign last_col  = (col == width_q - DW'(1));
  assign last_row  = (row == height_q - DW'(1));

  // ---------------------------------------------------------------------------
  // Control: state transitions and scan coordinate stepping
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d     = state;
    width_d     = width_q;
    height_d    = height_q;
    row_base_d  = row_base;
    col_d       = col;
    row_d       = row;
    out_valid_d = out_valid;
    busy_d      = busy;
    done_d      = 1'b0;
    load_win    = 1'b0;

    case (state)
      S_IDLE: begin
        out_valid_d = 1'b0;
        busy_d      = 1'b0;
        if (start) begin
          width_d  = cfg_width;
          height_d = cfg_height;
          if ((cfg_width != '0) && (cfg_height != '0)) begin
            row_base_d  = cfg_base;
            col_d       = '0;
            row_d       = '0;
            state_d     = S_RUN;
            out_valid_d = 1'b1;
            busy_d      = 1'b1;
            load_win    = 1'b1;
          end else begin
            // Empty frame: nothing to emit, report completion right away.
            state_d = S_DONE;
            done_d  = 1'b1;
          end
        end
      end

      S_RUN: begin
        if (abort) begin
          // abort wins over a handshake in the same cycle
          state_d     = S_IDLE;
          out_valid_d = 1'b0;
          busy_d      = 1'b0;
        end else if (handshake) begin
          if (last_col && last_row) begin
            state_d     = S_DONE;
            out_valid_d = 1'b0;
            busy_d      = 1'b0;
            done_d      = 1'b1;
          end else if (last_col) begin
            col_d      = '0;
            row_d      = row + DW'(1);
            row_base_d = row_base + AW'(width_q);
            load_win   = 1'b1;
          end else begin
            col_d    = col + DW'(1);
            load_win = 1'b1;
          end
        end
      end

      S_DONE: begin
        // done lasts one cycle; abort here lands in IDLE as well
        state_d     = S_IDLE;
        out_valid_d = 1'b0;
        busy_d      = 1'b0;
      end

      default: begin
        state_d     = S_IDLE;
        out_valid_d = 1'b0;
        busy_d      = 1'b0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Window address computation (modulo 2^AW)
  // ---------------------------------------------------------------------------
  always_comb begin
    width_ext_d = AW'(width_d);
    mid_d       = row_base_d + AW'(col_d);
    top_clamp_d = (row_d == '0);
    bot_clamp_d = (row_d == height_d - DW'(1));
    top_d       = top_clamp_d ? mid_d : (mid_d - width_ext_d);
    bot_d       = bot_clamp_d ? mid_d : (mid_d + width_ext_d);
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      width_q   <= '0;
      height_q  <= '0;
      row_base  <= '0;
      col       <= '0;
      row       <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      top_addr  <= '0;
      mid_addr  <= '0;
      bot_addr  <= '0;
      top_clamp <= 1'b0;
      bot_clamp <= 1'b0;
    end else begin
      state     <= state_d;
      width_q   <= width_d;
      height_q  <= height_d;
      row_base  <= row_base_d;
      col       <= col_d;
      row       <= row_d;
      out_valid <= out_valid_d;
      busy      <= busy_d;
      done      <= done_d;
      // Window outputs only move when a new window is loaded, so they are
      // stable under backpressure.
      if (load_win) begin
        top_addr  <= top_d;
        mid_addr  <= mid_d;
        bot_addr  <= bot_d;
        top_clamp <= top_clamp_d;
        bot_clamp <= bot_clamp_d;
      end
    end
  end

endmodule
